// File: rtl/stream_prefetch_pkg.sv
// stream_prefetch_pkg: shared FSM encoding, AXI read constants and 4 KB page helpers
package stream_prefetch_pkg;
   typedef enum logic [2:0] {IDLE, MISS_AR, MISS_R, PF_AR, PF_R} state_t;
   localparam logic [3:0] AXI_ID = 4'd0;
   localparam logic [2:0] AXI_SIZE = 3'b010;
   localparam logic [1:0] AXI_BURST = 2'b01;
   localparam logic [31:0] PAGE_MASK = 32'h0000_0fff;
   function automatic logic [4:0] burst_words(input logic [9:0] widx, input int blen);
      logic [10:0] left;
      left = 11'd1024 - {1'b0, widx};
      return (left < 11'(blen)) ? left[4:0] : 5'(blen);
   endfunction
endpackage

// File: rtl/stream_prefetch_way.sv
// stream_prefetch_way: one stream way, a circular word FIFO with head and next-fetch address tracking
module stream_prefetch_way
   import stream_prefetch_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          alloc,
   input  logic          set_valid,
   input  logic          push,
   input  logic          pop,
   input  logic          adv,
   input  logic [31:0]   alloc_addr,
   input  logic [31:0]   push_data,
   input  logic [4:0]    adv_len,
   output logic          valid,
   output logic          stall,
   output logic [CW-1:0] count,
   output logic [31:0]   head_addr,
   output logic [31:0]   next_addr,
   output logic [31:0]   head_data
);
   logic [31:0] mem [DEPTH];
   logic [AW-1:0] rd, wr;
   logic [31:0] next_adv;
   assign next_adv = next_addr + (32'(adv_len) << 2);
   assign head_data = mem[rd];
   always_ff @(posedge clk) if (push) mem[wr] <= push_data;
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid <= 1'b0;
         stall <= 1'b0;
         count <= '0;
         rd <= '0;
         wr <= '0;
         head_addr <= '0;
         next_addr <= '0;
      end else begin
         if (set_valid) valid <= 1'b1;
         if (push) wr <= (wr == AW'(DEPTH - 1)) ? '0 : wr + 1'b1;
         if (pop) begin
            rd <= (rd == AW'(DEPTH - 1)) ? '0 : rd + 1'b1;
            head_addr <= head_addr + 32'd4;
         end
         count <= count + CW'(push) - CW'(pop);
         // a page-stalled way stays stalled until it is reallocated
         if (adv) begin
            next_addr <= next_adv;
            stall <= (next_adv & PAGE_MASK) == '0;
         end
         if (flush || alloc) begin
            valid <= 1'b0;
            count <= '0;
            rd <= '0;
            wr <= '0;
         end
         if (alloc) begin
            stall <= 1'b0;
            head_addr <= alloc_addr + 32'd4;
            next_addr <= alloc_addr;
         end
      end
   end
endmodule

// File: rtl/stream_prefetch_ctrl.sv
// stream_prefetch_ctrl: multi-way sequential stream prefetcher serving word requests over AXI read bursts
module stream_prefetch_ctrl
   import stream_prefetch_pkg::*;
#(
   parameter int NUM_WAYS = 2,
   parameter int DEPTH = 8,
   parameter int BURST_LEN = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        target_req,
   input  logic [31:0] target_addr,
   output logic        target_addr_ok,
   output logic        target_data_ok,
   output logic [31:0] target_data,
   input  logic        flush,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);
   localparam int RW = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   state_t state;
   logic [RW-1:0] rr, tgt, hit_idx, pf_idx;
   logic first, drop, hit_ok, hit_any, pf_any, accept, miss, pf_go, beat, first_beat, keep;
   logic [4:0] cur_len, miss_len, pf_len;
   logic [31:0] data_q;
   logic [NUM_WAYS-1:0] valid_w, stall_w;
   logic [CW-1:0] count_w [NUM_WAYS];
   logic [31:0] head_addr_w [NUM_WAYS];
   logic [31:0] next_addr_w [NUM_WAYS];
   logic [31:0] head_data_w [NUM_WAYS];
   logic unused;
   assign unused = ^{rid, rresp};
   assign arid = AXI_ID;
   assign arsize = AXI_SIZE;
   assign arburst = AXI_BURST;
   assign arlock = 2'b00;
   assign arcache = 4'b0000;
   assign arprot = 3'b000;
   assign accept = rst && target_req && state == IDLE;
   assign target_addr_ok = accept;
   assign miss = accept && !hit_any;
   assign pf_go = rst && state == IDLE && !target_req && pf_any;
   assign beat = rready && rvalid;
   assign first_beat = rst && beat && state == MISS_R && first;
   assign keep = !drop && !flush;
   assign target_data_ok = hit_ok || first_beat;
   assign target_data = first_beat ? rdata : data_q;
   assign miss_len = burst_words(target_addr[11:2], BURST_LEN);
   assign pf_len = burst_words(next_addr_w[pf_idx][11:2], BURST_LEN);
   // descending scan so the lowest-index qualifying way wins
   always_comb begin
      hit_any = 1'b0;
      hit_idx = '0;
      pf_any = 1'b0;
      pf_idx = '0;
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (valid_w[i] && count_w[i] != '0 && head_addr_w[i] == target_addr) begin
            hit_any = 1'b1;
            hit_idx = RW'(i);
         end
         if (valid_w[i] && !stall_w[i] && int'(count_w[i]) + BURST_LEN <= DEPTH && (next_addr_w[i] & PAGE_MASK) != '0) begin
            pf_any = 1'b1;
            pf_idx = RW'(i);
         end
      end
   end
   for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      stream_prefetch_way #(.DEPTH(DEPTH)) u_way (
         .clk(clk),
         .rst(rst),
         .flush(flush),
         .alloc(miss && rr == RW'(w)),
         .set_valid(first_beat && keep && tgt == RW'(w)),
         .push(beat && !first_beat && keep && tgt == RW'(w)),
         .pop(accept && hit_any && hit_idx == RW'(w)),
         .adv(arvalid && arready && tgt == RW'(w)),
         .alloc_addr(target_addr),
         .push_data(rdata),
         .adv_len(cur_len),
         .valid(valid_w[w]),
         .stall(stall_w[w]),
         .count(count_w[w]),
         .head_addr(head_addr_w[w]),
         .next_addr(next_addr_w[w]),
         .head_data(head_data_w[w])
      );
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         rr <= '0;
         tgt <= '0;
         first <= 1'b0;
         drop <= 1'b0;
         hit_ok <= 1'b0;
         data_q <= '0;
         araddr <= '0;
         arlen <= '0;
         cur_len <= '0;
         arvalid <= 1'b0;
         rready <= 1'b0;
      end else begin
         hit_ok <= accept && hit_any;
         if (accept && hit_any) data_q <= head_data_w[hit_idx];
         // beats of a burst already in flight at flush are drained and discarded
         if (flush && (state != IDLE || pf_go)) drop <= 1'b1;
         case (state)
            IDLE:
               if (miss) begin
                  state <= MISS_AR;
                  tgt <= rr;
                  rr <= (rr == RW'(NUM_WAYS - 1)) ? '0 : rr + 1'b1;
                  araddr <= target_addr;
                  cur_len <= miss_len;
                  arlen <= {3'b000, miss_len - 5'd1};
                  arvalid <= 1'b1;
                  first <= 1'b1;
               end else if (pf_go) begin
                  state <= PF_AR;
                  tgt <= pf_idx;
                  araddr <= next_addr_w[pf_idx];
                  cur_len <= pf_len;
                  arlen <= {3'b000, pf_len - 5'd1};
                  arvalid <= 1'b1;
               end
            MISS_AR, PF_AR:
               if (arready) begin
                  arvalid <= 1'b0;
                  rready <= 1'b1;
                  state <= (state == MISS_AR) ? MISS_R : PF_R;
               end
            default: begin
               if (beat) first <= 1'b0;
               if (beat && rlast) begin
                  state <= IDLE;
                  rready <= 1'b0;
                  drop <= 1'b0;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_stream_prefetch_ctrl.sv
// tb_stream_prefetch_ctrl: scenario tasks with a returned-word scoreboard for the stream prefetcher
module tb_stream_prefetch_ctrl;
   import stream_prefetch_pkg::*;
   logic clk, rst, target_req, target_addr_ok, target_data_ok, flush;
   logic [31:0] target_addr, target_data, araddr, rdata;
   logic [3:0] arid, arcache, rid;
   logic [7:0] arlen;
   logic [2:0] arsize, arprot;
   logic [1:0] arburst, arlock, rresp;
   logic arvalid, arready, rlast, rvalid, rready;
   int compared = 0;
   int mismatched = 0;
   logic [31:0] exp_q [$];
   logic [31:0] exp_d;

   stream_prefetch_ctrl dut (
      .clk(clk), .rst(rst),
      .target_req(target_req), .target_addr(target_addr),
      .target_addr_ok(target_addr_ok), .target_data_ok(target_data_ok), .target_data(target_data),
      .flush(flush),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   // scoreboard: every data_ok pulse must match the oldest accepted request
   always @(negedge clk) begin
      if (target_data_ok === 1'b1) begin
         compared++;
         if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL data_ok: unexpected pulse with data %h, want no pulse", target_data);
         end else begin
            exp_d = exp_q.pop_front();
            if (target_data !== exp_d) begin
               mismatched++;
               $display("FAIL data: got %h want %h", target_data, exp_d);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [31:0] a, input logic hit, input string nm);
      target_req = 1'b1;
      target_addr = a;
      exp_q.push_back(mem_word(a));
      #1;
      compared++;
      if (target_addr_ok !== 1'b1) begin
         mismatched++;
         $display("FAIL %s addr_ok: got %b want 1", nm, target_addr_ok);
      end
      tick();
      target_req = 1'b0;
      compared++;
      if (arvalid !== !hit) begin
         mismatched++;
         $display("FAIL %s hit/miss: arvalid got %b want %b", nm, arvalid, !hit);
      end
   endtask

   task automatic do_ar(input logic [31:0] a, input logic [7:0] l, input string nm);
      int n = 0;
      while (arvalid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      compared++;
      if (arvalid !== 1'b1 || araddr !== a || arlen !== l) begin
         mismatched++;
         $display("FAIL %s ar: arvalid=%b araddr=%h arlen=%0d, want 1 %h %0d", nm, arvalid, araddr, arlen, a, l);
      end
      arready = 1'b1;
      tick();
      arready = 1'b0;
   endtask

   task automatic do_beats(input logic [31:0] a, input int n, input int fa, input string nm);
      for (int i = 0; i < n; i++) begin
         rvalid = 1'b1;
         rdata = mem_word(a + 32'(4 * i));
         rlast = (i == n - 1);
         flush = (i == fa);
         #1;
         compared++;
         if (rready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s beat %0d rready: got %b want 1", nm, i, rready);
         end
         tick();
      end
      rvalid = 1'b0;
      rlast = 1'b0;
      flush = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      target_req = 1'b1;
      target_addr = 32'h1FC0_0000;
      repeat (3) tick();
      compared++;
      if ({target_addr_ok, target_data_ok, arvalid, rready} !== 4'b0000 || target_data !== 32'h0 || dut.state !== IDLE || dut.rr !== 1'b0) begin
         mismatched++;
         $display("FAIL reset: addr_ok=%b data_ok=%b arvalid=%b rready=%b data=%h, want all zero and IDLE",
                  target_addr_ok, target_data_ok, arvalid, rready, target_data);
      end
      target_req = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_cold_miss();
      req(32'h1FC0_0000, 1'b0, "cold");
      do_ar(32'h1FC0_0000, 8'd3, "cold");
      do_beats(32'h1FC0_0000, 4, -1, "cold");
      compared++;
      if (dut.g_way[0].u_way.valid !== 1'b1 || dut.g_way[0].u_way.head_addr !== 32'h1FC0_0004 || dut.g_way[0].u_way.count !== 3) begin
         mismatched++;
         $display("FAIL cold way0: valid=%b head=%h count=%0d, want 1 1fc00004 3",
                  dut.g_way[0].u_way.valid, dut.g_way[0].u_way.head_addr, dut.g_way[0].u_way.count);
      end
   endtask

   task automatic test_hit_run();
      req(32'h1FC0_0004, 1'b1, "hit04");
      req(32'h1FC0_0008, 1'b1, "hit08");
      do_ar(32'h1FC0_0010, 8'd3, "pf10");
      do_beats(32'h1FC0_0010, 4, -1, "pf10");
      req(32'h1FC0_000C, 1'b1, "hit0c");
      req(32'h1FC0_0010, 1'b1, "hit10");
   endtask

   task automatic test_flush_pf();
      do_ar(32'h1FC0_0020, 8'd3, "pf20");
      do_beats(32'h1FC0_0020, 4, 1, "flush");
      compared++;
      if (dut.g_way[0].u_way.valid !== 1'b0 || dut.g_way[1].u_way.valid !== 1'b0 || dut.state !== IDLE) begin
         mismatched++;
         $display("FAIL flush: way0 valid=%b way1 valid=%b state=%0d, want 0 0 IDLE",
                  dut.g_way[0].u_way.valid, dut.g_way[1].u_way.valid, dut.state);
      end
      req(32'h1FC0_0014, 1'b0, "postflush");
      do_ar(32'h1FC0_0014, 8'd3, "postflush");
      do_beats(32'h1FC0_0014, 4, 3, "postflush");
   endtask

   task automatic test_page_clamp();
      req(32'h0000_0FF8, 1'b0, "clamp");
      do_ar(32'h0000_0FF8, 8'd1, "clamp");
      do_beats(32'h0000_0FF8, 2, -1, "clamp");
      for (int i = 0; i < 8; i++) begin
         tick();
         compared++;
         if (arvalid !== 1'b0) begin
            mismatched++;
            $display("FAIL clamp idle %0d: arvalid got %b want 0", i, arvalid);
         end
      end
      req(32'h0000_0FFC, 1'b1, "clamp_hit");
      for (int i = 0; i < 4; i++) begin
         tick();
         compared++;
         if (arvalid !== 1'b0) begin
            mismatched++;
            $display("FAIL clamp drained idle %0d: arvalid got %b want 0", i, arvalid);
         end
      end
   endtask

   task automatic test_reset_mid_miss();
      req(32'h0000_4000, 1'b0, "rstmiss");
      do_ar(32'h0000_4000, 8'd3, "rstmiss");
      rvalid = 1'b1;
      rdata = mem_word(32'h0000_4000);
      rlast = 1'b0;
      tick();
      rst = 1'b0;
      rdata = mem_word(32'h0000_4004);
      target_req = 1'b1;
      target_addr = 32'h0000_4004;
      tick();
      compared++;
      if ({target_addr_ok, target_data_ok, arvalid, rready} !== 4'b0000 || target_data !== 32'h0 || dut.state !== IDLE
          || dut.rr !== 1'b0 || dut.g_way[1].u_way.valid !== 1'b0) begin
         mismatched++;
         $display("FAIL reset mid miss: addr_ok=%b data_ok=%b arvalid=%b rready=%b data=%h, want all zero and IDLE",
                  target_addr_ok, target_data_ok, arvalid, rready, target_data);
      end
      rvalid = 1'b0;
      target_req = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_round_robin();
      req(32'h0000_1000, 1'b0, "rr1000");
      do_ar(32'h0000_1000, 8'd3, "rr1000");
      do_beats(32'h0000_1000, 4, -1, "rr1000");
      req(32'h0000_2000, 1'b0, "rr2000");
      do_ar(32'h0000_2000, 8'd3, "rr2000");
      do_beats(32'h0000_2000, 4, -1, "rr2000");
      compared++;
      if (dut.g_way[0].u_way.head_addr !== 32'h0000_1004 || dut.g_way[1].u_way.head_addr !== 32'h0000_2004) begin
         mismatched++;
         $display("FAIL rr victims 1: way0 head=%h way1 head=%h, want 00001004 00002004",
                  dut.g_way[0].u_way.head_addr, dut.g_way[1].u_way.head_addr);
      end
      req(32'h0000_3000, 1'b0, "rr3000");
      do_ar(32'h0000_3000, 8'd3, "rr3000");
      do_beats(32'h0000_3000, 4, -1, "rr3000");
      compared++;
      if (dut.g_way[0].u_way.head_addr !== 32'h0000_3004 || dut.g_way[1].u_way.head_addr !== 32'h0000_2004) begin
         mismatched++;
         $display("FAIL rr victims 2: way0 head=%h way1 head=%h, want 00003004 00002004",
                  dut.g_way[0].u_way.head_addr, dut.g_way[1].u_way.head_addr);
      end
      req(32'h0000_1004, 1'b0, "evicted");
      do_ar(32'h0000_1004, 8'd3, "evicted");
      do_beats(32'h0000_1004, 4, 3, "evicted");
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b0;
      target_req = 1'b0;
      target_addr = '0;
      flush = 1'b0;
      arready = 1'b0;
      rid = '0;
      rdata = '0;
      rresp = '0;
      rlast = 1'b0;
      rvalid = 1'b0;
      test_reset();
      test_cold_miss();
      test_hit_run();
      test_flush_pf();
      test_page_clamp();
      test_reset_mid_miss();
      test_round_robin();
      repeat (4) tick();
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL scoreboard: %0d words never returned, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
